// File: rtl/max_tracker_pkg.sv
// rtl/max_tracker_pkg.sv - shared state encoding and default constants for max_tracker
//
// Purpose : state type and default parameter values shared by max_tracker
//           and its compare stage.
// Ports   : none (package).
package max_tracker_pkg;

  // Frame FSM: collecting samples, or presenting a finished result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_FRAME_LEN = 8;

endpackage

// File: rtl/max_cmp_stage.sv
// rtl/max_cmp_stage.sv - combinational compare-and-select of candidate vs current extreme
//
// Purpose : picks either the candidate (value, index) or the current
//           (value, index). The candidate wins when force_sel is set or when
//           it is strictly better: larger by default, smaller when INVERT=1.
//           Strict compare keeps the earlier index on ties.
// Ports   : force_sel - take the candidate unconditionally (first sample)
//           cand_val/cand_idx - incoming sample and its position
//           cur_val/cur_idx   - extreme held so far
//           sel_val/sel_idx   - selected extreme
module max_cmp_stage #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned IDXW   = 3,
  parameter bit          INVERT = 1'b0
) (
  input  logic             force_sel,
  input  logic [WIDTH-1:0] cand_val,
  input  logic [IDXW-1:0]  cand_idx,
  input  logic [WIDTH-1:0] cur_val,
  input  logic [IDXW-1:0]  cur_idx,
  output logic [WIDTH-1:0] sel_val,
  output logic [IDXW-1:0]  sel_idx
);

  logic better;
  logic take;

  // Both operands are unsigned of equal width, so the compare cannot overflow.
  always_comb begin
    better = 1'b0;
    if (INVERT) begin
      better = (cand_val < cur_val);
    end else begin
      better = (cand_val > cur_val);
    end
  end

  assign take    = force_sel | better;
  assign sel_val = take ? cand_val : cur_val;
  assign sel_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/max_tracker.sv
// rtl/max_tracker.sv - per-frame maximum tracker with valid/ready handshakes
//
// Purpose : accepts FRAME_LEN unsigned samples per frame, then holds the
//           frame maximum, index of its first occurrence and an all-equal
//           flag until the consumer takes them.
// Config  : define MAX_TRACKER_MIN_EN to also track the minimum and the
//           index of its first occurrence.
// Ports   : clk, rst (synchronous, active-high)
//           in_valid/in_ready/in_data   - sample input handshake
//           out_valid/out_ready         - result output handshake
//           out_max, out_idx, out_all_eq - frame result
//           out_min, out_min_idx         - frame minimum (MAX_TRACKER_MIN_EN only)
module max_tracker
  import max_tracker_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned FRAME_LEN = DEF_FRAME_LEN,
  localparam int unsigned IDXW      = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_idx,
`ifdef MAX_TRACKER_MIN_EN
  output logic [WIDTH-1:0] out_min,
  output logic [IDXW-1:0]  out_min_idx,
`endif
  output logic             out_all_eq
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

  state_e           state_q;
  logic [IDXW-1:0]  cnt_q;
  logic [WIDTH-1:0] max_q;
  logic [IDXW-1:0]  idx_q;
  logic             all_eq_q;
  logic [WIDTH-1:0] s0_q;      // sample 0 of the current frame, reference for all_eq

  logic             first;
  logic             last;
  logic [WIDTH-1:0] max_d;
  logic [IDXW-1:0]  idx_d;
  logic             all_eq_d;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == LAST_IDX);

  // Sample 0 compares against itself, so all_eq starts at 1 for a new frame.
  assign all_eq_d = first | (all_eq_q & (in_data == s0_q));

  max_cmp_stage #(
    .WIDTH  (WIDTH),
    .IDXW   (IDXW),
    .INVERT (1'b0)
  ) u_max_cmp (
    .force_sel (first),
    .cand_val  (in_data),
    .cand_idx  (cnt_q),
    .cur_val   (max_q),
    .cur_idx   (idx_q),
    .sel_val   (max_d),
    .sel_idx   (idx_d)
  );

`ifdef MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0] min_q;
  logic [IDXW-1:0]  min_idx_q;
  logic [WIDTH-1:0] min_d;
  logic [IDXW-1:0]  min_idx_d;

  max_cmp_stage #(
    .WIDTH  (WIDTH),
    .IDXW   (IDXW),
    .INVERT (1'b1)
  ) u_min_cmp (
    .force_sel (first),
    .cand_val  (in_data),
    .cand_idx  (cnt_q),
    .cur_val   (min_q),
    .cur_idx   (min_idx_q),
    .sel_val   (min_d),
    .sel_idx   (min_idx_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q     <= '0;
      min_idx_q <= '0;
    end else if ((state_q == ACCUM) && in_valid) begin
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign out_min     = min_q;
  assign out_min_idx = min_idx_q;
`endif

  // Frame FSM and accumulators. in_ready/out_valid decode directly from the
  // state register, so they are glitch-free registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      all_eq_q <= 1'b0;
      s0_q     <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            max_q    <= max_d;
            idx_q    <= idx_d;
            all_eq_q <= all_eq_d;
            if (first) begin
              s0_q <= in_data;
            end
            if (last) begin
              cnt_q   <= '0;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + IDXW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_max    = max_q;
  assign out_idx    = idx_q;
  assign out_all_eq = all_eq_q;

endmodule

// File: tb/tb_max_tracker.sv
// tb/tb_max_tracker.sv - self-checking bench for max_tracker (WIDTH=4, FRAME_LEN=4)
//
// Purpose : directed frames plus randomized frames with input gaps and
//           output stalls, checked against a frame-level reference model.
// Ports   : none (top-level bench).
module tb_max_tracker;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned IDXW      = $clog2(FRAME_LEN);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDXW-1:0]  out_idx;
  logic             out_all_eq;
`ifdef MAX_TRACKER_MIN_EN
  logic [WIDTH-1:0] out_min;
  logic [IDXW-1:0]  out_min_idx;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] frame [FRAME_LEN];
  int               exp_max, exp_idx, exp_eq, exp_min, exp_min_idx;

  max_tracker #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_idx     (out_idx),
`ifdef MAX_TRACKER_MIN_EN
    .out_min     (out_min),
    .out_min_idx (out_min_idx),
`endif
    .out_all_eq  (out_all_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level model: maximum and minimum by scanning the whole frame, then
  // the index is the first position holding that value.
  task automatic compute_expected();
    int mx, mn;
    mx = 0;
    mn = (1 << WIDTH) - 1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (int'(frame[i]) > mx) mx = int'(frame[i]);
      if (int'(frame[i]) < mn) mn = int'(frame[i]);
    end
    exp_max = mx;
    exp_min = mn;
    exp_idx = -1;
    exp_min_idx = -1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (exp_idx < 0 && int'(frame[i]) == mx) exp_idx = i;
      if (exp_min_idx < 0 && int'(frame[i]) == mn) exp_min_idx = i;
    end
    exp_eq = (mx == mn) ? 1 : 0;
  endtask

  task automatic check_result(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".out_max"}, 32'(out_max), 32'(exp_max));
    check({tag, ".out_idx"}, 32'(out_idx), 32'(exp_idx));
    check({tag, ".out_all_eq"}, 32'(out_all_eq), 32'(exp_eq));
`ifdef MAX_TRACKER_MIN_EN
    check({tag, ".out_min"}, 32'(out_min), 32'(exp_min));
    check({tag, ".out_min_idx"}, 32'(out_min_idx), 32'(exp_min_idx));
`endif
  endtask

  // Feeds the frame in 'frame'; with max_gap>0, idle cycles carrying junk
  // data and random out_ready are inserted before samples. Returns one
  // cycle after the last sample was accepted, with the DUT in HOLD.
  task automatic send_frame(input string tag, input int max_gap);
    compute_expected();
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) begin
          in_valid  = 1'b0;
          in_data   = WIDTH'($urandom);
          out_ready = 1'($urandom);
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      check({tag, ".in_ready_accum"}, 32'(in_ready), 32'd1);
      if (i == FRAME_LEN - 1) check({tag, ".out_valid_early"}, 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;
    check_result(tag);
  endtask

  // Stall the consumer for 'stall' cycles while pushing junk samples, then
  // take the result and confirm the block is ready for a new frame.
  task automatic release_result(input string tag, input int stall, input logic [WIDTH-1:0] junk);
    out_ready = 1'b0;
    for (int c = 0; c < stall; c++) begin
      in_valid = 1'b1;
      in_data  = junk;
      step();
      check_result({tag, ".stall"});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_max", 32'(out_max), 32'd0);
    check("reset.out_idx", 32'(out_idx), 32'd0);
    check("reset.out_all_eq", 32'(out_all_eq), 32'd0);
    rst = 1'b0;
    check("reset.in_ready", 32'(in_ready), 32'd1);

    // Mixed frame, max in the middle.
    frame = '{4'd3, 4'd9, 4'd2, 4'd7};
    send_frame("f3927", 0);
    check("f3927.max_const", 32'(out_max), 32'd9);
    check("f3927.idx_const", 32'(out_idx), 32'd1);
    release_result("f3927", 0, 4'h0);

    // All equal.
    frame = '{4'd5, 4'd5, 4'd5, 4'd5};
    send_frame("f5555", 0);
    check("f5555.eq_const", 32'(out_all_eq), 32'd1);
    release_result("f5555", 0, 4'h0);

    // Repeated maximum keeps the first index.
    frame = '{4'd2, 4'hF, 4'd1, 4'hF};
    send_frame("f2F1F", 0);
    check("f2F1F.idx_const", 32'(out_idx), 32'd1);
    release_result("f2F1F", 0, 4'h0);

    // Consumer stalls three cycles while junk 0xE is offered.
    frame = '{4'd3, 4'd9, 4'd2, 4'd7};
    send_frame("stall", 0);
    release_result("stall", 3, 4'hE);
    frame = '{4'd1, 4'd2, 4'd3, 4'd4};
    send_frame("f1234", 0);
    check("f1234.idx_const", 32'(out_idx), 32'd3);
    release_result("f1234", 0, 4'h0);

    // Reset in the middle of a frame discards it.
    in_valid = 1'b1;
    in_data  = 4'd8;
    step();
    in_data  = 4'd6;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    check("midrst.out_max", 32'(out_max), 32'd0);
    check("midrst.out_idx", 32'(out_idx), 32'd0);
    check("midrst.out_all_eq", 32'(out_all_eq), 32'd0);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    frame = '{4'd1, 4'd0, 4'd1, 4'd0};
    send_frame("f1010", 0);
    release_result("f1010", 0, 4'h0);

    // Randomized frames; some drawn from a tiny value range to hit ties and all-equal.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (n % 3 == 0) frame[i] = WIDTH'($urandom_range(1, 0) + 6);
        else            frame[i] = WIDTH'($urandom);
      end
      send_frame($sformatf("rnd%0d", n), 2);
      release_result($sformatf("rnd%0d", n), $urandom_range(3, 0), WIDTH'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Whole-run watchdog so the bench always ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
